// File: rtl/video_timing_box_gen_if.sv
// rtl/video_timing_box_gen_if.sv - box bounds, pixel input and raster/overlay outputs of video_timing_box_gen
interface video_timing_box_gen_if;
  logic [12:0] x_min1;
  logic [12:0] x_max1;
  logic [12:0] y_min1;
  logic [12:0] y_max1;
  logic [23:0] pix_in;
  logic        HSync;
  logic        VSync;
  logic        VDE;
  logic [10:0] x_num;
  logic [9:0]  y_num;
  logic [23:0] pix_out;
  logic        hs_out;
  logic        vs_out;
  logic        de_out;

  // Pixel source / detector side: drives bounds and pixels, consumes timing.
  modport master (
    output x_min1, x_max1, y_min1, y_max1, pix_in,
    input  HSync, VSync, VDE, x_num, y_num, pix_out, hs_out, vs_out, de_out
  );

  // Timing generator / overlay side.
  modport slave (
    input  x_min1, x_max1, y_min1, y_max1, pix_in,
    output HSync, VSync, VDE, x_num, y_num, pix_out, hs_out, vs_out, de_out
  );
endinterface

// File: rtl/video_timing_box_gen.sv
// rtl/video_timing_box_gen.sv - raster timing generator with per-frame box outline overlay (option: BOX_CROSSHAIR_EN)
module video_timing_box_gen #(
  parameter int          H_ACT   = 1280,
  parameter int          H_FP    = 110,
  parameter int          H_SYNC  = 40,
  parameter int          H_BP    = 220,
  parameter int          V_ACT   = 720,
  parameter int          V_FP    = 5,
  parameter int          V_SYNC  = 5,
  parameter int          V_BP    = 20,
  parameter bit          HS_POL  = 1'b0,
  parameter bit          VS_POL  = 1'b1,
  parameter int          BOX_W   = 2,
  parameter logic [23:0] BOX_RGB = 24'hFF0000
) (
  input logic                  clk,
  input logic                  rst,
  video_timing_box_gen_if.slave vif
);

  localparam logic [10:0] H_A    = 11'(H_ACT);
  localparam logic [10:0] H_SS   = 11'(H_ACT + H_FP);
  localparam logic [10:0] H_SE   = 11'(H_ACT + H_FP + H_SYNC);
  localparam logic [10:0] H_LAST = 11'(H_ACT + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0]  V_A    = 10'(V_ACT);
  localparam logic [9:0]  V_SS   = 10'(V_ACT + V_FP);
  localparam logic [9:0]  V_SE   = 10'(V_ACT + V_FP + V_SYNC);
  localparam logic [9:0]  V_LAST = 10'(V_ACT + V_FP + V_SYNC + V_BP - 1);
  localparam logic [12:0] BW     = 13'(BOX_W);

  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;

  logic h_act, v_act, h_sync, v_sync, capture;

  assign h_act   = (h_cnt < H_A);
  assign v_act   = (v_cnt < V_A);
  assign h_sync  = (h_cnt >= H_SS) && (h_cnt < H_SE);
  assign v_sync  = (v_cnt >= V_SS) && (v_cnt < V_SE);
  // First cycle of the VSync line: latch the box for the next frame here so
  // the whole visible frame uses one consistent box.
  assign capture = (v_cnt == V_SS) && (h_cnt == 11'd0);

  // Raster counters: h wraps each line, v advances on the h wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= 11'd0;
      v_cnt <= 10'd0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= 11'd0;
      v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 11'd1;
    end
  end

  // Registered timing outputs, all derived from the same counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vif.HSync <= ~HS_POL;
      vif.VSync <= ~VS_POL;
      vif.VDE   <= 1'b0;
      vif.x_num <= 11'd0;
      vif.y_num <= 10'd0;
    end else begin
      vif.HSync <= h_sync ? HS_POL : ~HS_POL;
      vif.VSync <= v_sync ? VS_POL : ~VS_POL;
      vif.VDE   <= h_act && v_act;
      vif.x_num <= (h_act && v_act) ? h_cnt : 11'd0;
      vif.y_num <= (h_act && v_act) ? v_cnt : 10'd0;
    end
  end

  logic [12:0] xmn, xmx, ymn, ymx;
  logic        box_valid;

  // Shadow copy of the detector box, refreshed once per frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xmn       <= 13'd0;
      xmx       <= 13'd0;
      ymn       <= 13'd0;
      ymx       <= 13'd0;
      box_valid <= 1'b0;
    end else if (capture) begin
      xmn       <= vif.x_min1;
      xmx       <= vif.x_max1;
      ymn       <= vif.y_min1;
      ymx       <= vif.y_max1;
      box_valid <= (vif.x_min1 <= vif.x_max1) && (vif.y_min1 <= vif.y_max1);
    end
  end

  logic [12:0] x, y;
  logic        in_box, border, hit;

  assign x      = {2'b00, vif.x_num};
  assign y      = {3'b000, vif.y_num};
  assign in_box = (x >= xmn) && (x <= xmx) && (y >= ymn) && (y <= ymx);
  // Thin boxes collapse to solid naturally: every inside pixel is near an edge.
  assign border = in_box && ((x < 13'(xmn + BW)) || (13'(x + BW) > xmx) ||
                             (y < 13'(ymn + BW)) || (13'(y + BW) > ymx));

`ifdef BOX_CROSSHAIR_EN
  logic [12:0] cx, cy;
  logic [13:0] sum_x, sum_y;

  assign sum_x = {1'b0, vif.x_min1} + {1'b0, vif.x_max1};
  assign sum_y = {1'b0, vif.y_min1} + {1'b0, vif.y_max1};

  // Box centre, computed alongside the shadow capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cx <= 13'd0;
      cy <= 13'd0;
    end else if (capture) begin
      cx <= 13'(sum_x >> 1);
      cy <= 13'(sum_y >> 1);
    end
  end

  assign hit = border || (in_box && ((x == cx) || (y == cy)));
`else
  assign hit = border;
`endif

  // One-cycle overlay stage with syncs delayed to stay aligned to pix_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vif.pix_out <= 24'd0;
      vif.hs_out  <= ~HS_POL;
      vif.vs_out  <= ~VS_POL;
      vif.de_out  <= 1'b0;
    end else begin
      vif.pix_out <= (vif.VDE && box_valid && hit) ? BOX_RGB :
                     (vif.VDE ? vif.pix_in : 24'd0);
      vif.hs_out  <= vif.HSync;
      vif.vs_out  <= vif.VSync;
      vif.de_out  <= vif.VDE;
    end
  end

endmodule

// File: tb/tb_video_timing_box_gen.sv
// tb/tb_video_timing_box_gen.sv - directed self-checking bench for video_timing_box_gen on a reduced raster
module tb_video_timing_box_gen;
  localparam int HA = 40, HF = 4, HS = 4, HB = 8;
  localparam int VA = 20, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int BUDGET = 2 * FRAME;
  localparam logic [23:0] RED = 24'hFF0000;
  localparam logic [23:0] GRN = 24'h00FF00;
  localparam logic [23:0] ALT = 24'h123456;
`ifdef BOX_CROSSHAIR_EN
  localparam logic [23:0] CROSS = RED;
`else
  localparam logic [23:0] CROSS = GRN;
`endif

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  video_timing_box_gen_if vif ();

  video_timing_box_gen #(
    .H_ACT(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACT(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vif(vif)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_pix(input int x, input int y);
    int n = 0;
    while (!(vif.VDE === 1'b1 && vif.x_num == x[10:0] && vif.y_num == y[9:0]) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (n >= BUDGET) begin
      tests++;
      fails++;
      $error("FAIL wait_pix(%0d,%0d) timed out after %0d cycles", x, y, n);
    end
  endtask

  task automatic check_px(input string tag, input int x, input int y, input logic [23:0] exp);
    wait_pix(x, y);
    @(negedge clk);
    chk(tag, {8'd0, vif.pix_out}, {8'd0, exp});
  endtask

  task automatic set_box(input int a, input int b, input int c, input int d);
    vif.x_min1 = a[12:0];
    vif.x_max1 = b[12:0];
    vif.y_min1 = c[12:0];
    vif.y_max1 = d[12:0];
  endtask

  initial begin
    int h, v, vde_cnt, hs_low, vs_high;
    int bad_hs, bad_vs, bad_de, bad_x, bad_y, bad_pix, bad_dly;
    logic e_de, e_hs, e_vs, p_de, p_hs, p_vs;
    logic [10:0] e_x;
    logic [9:0]  e_y;

    rst = 1'b1;
    vif.pix_in = GRN;
    set_box(10, 30, 5, 15);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_vde", vif.VDE, 0);
    chk("rst_xnum", vif.x_num, 0);
    chk("rst_ynum", vif.y_num, 0);
    chk("rst_hsync", vif.HSync, 1);
    chk("rst_vsync", vif.VSync, 0);
    chk("rst_pix_out", vif.pix_out, 0);
    chk("rst_de_out", vif.de_out, 0);
    chk("rst_hs_out", vif.hs_out, 1);
    chk("rst_vs_out", vif.vs_out, 0);
    rst = 1'b0;

    @(negedge clk);
    chk("first_vde", vif.VDE, 1);
    chk("first_xnum", vif.x_num, 0);
    chk("first_ynum", vif.y_num, 0);

    // Frame 0: full raster model; shadow box is still the reset (invalid) one.
    vde_cnt = 0; hs_low = 0; vs_high = 0;
    bad_hs = 0; bad_vs = 0; bad_de = 0; bad_x = 0; bad_y = 0; bad_pix = 0; bad_dly = 0;
    p_de = 1'b0; p_hs = 1'b1; p_vs = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      h = k % HT;
      v = k / HT;
      e_de = (h < HA) && (v < VA);
      e_hs = !((h >= HA + HF) && (h < HA + HF + HS));
      e_vs = (v >= VA + VF) && (v < VA + VF + VS);
      e_x  = e_de ? h[10:0] : 11'd0;
      e_y  = e_de ? v[9:0] : 10'd0;
      if (vif.VDE === 1'b1) vde_cnt++;
      if (vif.HSync === 1'b0) hs_low++;
      if (vif.VSync === 1'b1) vs_high++;
      if (vif.HSync !== e_hs) bad_hs++;
      if (vif.VSync !== e_vs) bad_vs++;
      if (vif.VDE !== e_de) bad_de++;
      if (vif.x_num !== e_x) bad_x++;
      if (vif.y_num !== e_y) bad_y++;
      if (vif.pix_out !== (p_de ? GRN : 24'd0)) bad_pix++;
      if (vif.de_out !== p_de || vif.hs_out !== p_hs || vif.vs_out !== p_vs) bad_dly++;
      p_de = e_de; p_hs = e_hs; p_vs = e_vs;
      @(negedge clk);
    end
    chk("frame_vde_count", vde_cnt, HA * VA);
    chk("frame_hsync_low_count", hs_low, VT * HS);
    chk("frame_vsync_high_count", vs_high, VS * HT);
    chk("frame_hsync_pattern_errs", bad_hs, 0);
    chk("frame_vsync_pattern_errs", bad_vs, 0);
    chk("frame_vde_pattern_errs", bad_de, 0);
    chk("frame_xnum_errs", bad_x, 0);
    chk("frame_ynum_errs", bad_y, 0);
    chk("frame0_passthrough_errs", bad_pix, 0);
    chk("frame_delay_align_errs", bad_dly, 0);
    chk("wrap_vde", vif.VDE, 1);
    chk("wrap_xnum", vif.x_num, 0);
    chk("wrap_ynum", vif.y_num, 0);

    // Frame 1: box (10,30,5,15) outline, BOX_W = 2.
    check_px("f1_above_box", 20, 4, GRN);
    check_px("f1_top_edge", 20, 5, RED);
    check_px("f1_top_inner", 20, 6, RED);
    check_px("f1_left_outside", 9, 8, GRN);
    check_px("f1_left_edge", 10, 8, RED);
    check_px("f1_interior", 28, 8, GRN);
    check_px("f1_right_inner", 29, 8, RED);
    check_px("f1_right_edge", 30, 8, RED);
    check_px("f1_right_outside", 31, 8, GRN);
    check_px("f1_cross_row", 15, 10, CROSS);
    check_px("f1_cross_col", 20, 12, CROSS);
    check_px("f1_interior_low", 25, 13, GRN);
    check_px("f1_bottom_inner", 20, 14, RED);

    // Frame 2: inverted x bounds -> box_valid = 0, pixels pass through.
    set_box(32, 20, 5, 15);
    vif.pix_in = ALT;
    check_px("f2_inval_top", 20, 5, ALT);
    check_px("f2_inval_left", 10, 8, ALT);
    check_px("f2_inval_right", 30, 8, ALT);
    wait_pix(0, 16);
    set_box(10, 30, 5, 15);
    vif.pix_in = GRN;

    // Frame 3: box changed mid-frame; the old box must remain.
    wait_pix(0, 12);
    set_box(0, 5, 0, 3);
    check_px("f3_old_left", 10, 13, RED);
    check_px("f3_old_bottom", 20, 14, RED);

    // Frame 4: the new small box is now in effect, the old one is gone.
    check_px("f4_new_box", 2, 2, RED);
    check_px("f4_old_gone", 20, 14, GRN);

    // Mid-frame asynchronous reset aborts the frame and restarts at (0,0).
    wait_pix(0, 5);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_vde", vif.VDE, 0);
    chk("midrst_ynum", vif.y_num, 0);
    chk("midrst_hsync", vif.HSync, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_restart_vde", vif.VDE, 1);
    chk("midrst_restart_xnum", vif.x_num, 0);
    chk("midrst_restart_ynum", vif.y_num, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
